// File: rtl/sys_init_seq.sv
// rtl/sys_init_seq.sv - launches N init sub-blocks (parallel or in order) and watches each for timeout
// Optional feature macro: SYS_INIT_RETRY_EN (re-launch timed-out channels up to MAX_RETRY times).
module sys_init_seq #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TIMEOUT_W   = 24,
  parameter int unsigned TIMEOUT_CYC = 24'd10_000_000,
  parameter int unsigned SEQ_MODE    = 0,
  parameter int unsigned MAX_RETRY   = 2,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
`ifdef SYS_INIT_RETRY_EN
  , localparam int unsigned RC_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [NUM_CH-1:0] err_mask,
  output logic [CH_W-1:0]   cur_ch
`ifdef SYS_INIT_RETRY_EN
  , output logic [RC_W-1:0] retry_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_FAIL} state_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  state_t               state, state_n;
  logic [NUM_CH-1:0]    en_q, en_n, done_q, done_q_n, err_n, start_n;
  logic [NUM_CH-1:0]    target, done_new, pending;
  logic [CH_W-1:0]      cur_n;
  logic [TIMEOUT_W-1:0] timer, timer_n;
  logic                 done_n, error_n;
`ifdef SYS_INIT_RETRY_EN
  logic [RC_W-1:0]      retry_n;
`endif

  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--)
      if (m[i]) idx = CH_W'(i);
    return idx;
  endfunction

  // Channel selection for a phase: every channel in parallel mode, only cur_ch in sequential mode.
  function automatic logic [NUM_CH-1:0] sel(input logic [CH_W-1:0] idx);
    return (SEQ_MODE != 0) ? (NUM_CH'(1) << idx) : '1;
  endfunction

  assign busy = (state != S_IDLE);

  always_comb begin
    state_n  = state;
    en_n     = en_q;
    done_q_n = done_q;
    err_n    = err_mask;
    cur_n    = cur_ch;
    start_n  = '0;
    timer_n  = timer;
    done_n   = done;
    error_n  = error;
`ifdef SYS_INIT_RETRY_EN
    retry_n  = retry_cnt;
`endif
    target   = en_q & sel(cur_ch);
    done_new = done_q | (ch_done & target);
    pending  = target & ~done_new;

    case (state)
      S_IDLE: begin
        if (start) begin
          en_n     = ch_en;
          done_q_n = '0;
          err_n    = '0;
          done_n   = 1'b0;
          error_n  = 1'b0;
          if (SEQ_MODE != 0) cur_n = lowest(ch_en);
          start_n  = ch_en & sel(cur_n);
`ifdef SYS_INIT_RETRY_EN
          retry_n  = '0;
`endif
          state_n  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        done_q_n = done_new;
        if (timer != {TIMEOUT_W{1'b1}}) timer_n = timer + 1'b1;
        // Completion is tested first so it wins over a same-cycle timeout.
        if (pending == '0) begin
          if ((SEQ_MODE != 0) && ((en_q & ~done_new) != '0)) begin
            cur_n   = lowest(en_q & ~done_new);
            start_n = en_q & sel(cur_n);
`ifdef SYS_INIT_RETRY_EN
            retry_n = '0;
`endif
            state_n = S_LAUNCH;
          end else begin
            state_n = S_DONE;
          end
        end else if (timer == TO_LAST) begin
`ifdef SYS_INIT_RETRY_EN
          if (retry_cnt < RC_W'(MAX_RETRY)) begin
            retry_n = retry_cnt + 1'b1;
            start_n = pending;
            state_n = S_LAUNCH;
          end else begin
            err_n   = err_mask | pending;
            state_n = S_FAIL;
          end
`else
          err_n   = err_mask | pending;
          state_n = S_FAIL;
`endif
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      S_FAIL: begin
        error_n = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      en_q      <= '0;
      done_q    <= '0;
      err_mask  <= '0;
      cur_ch    <= '0;
      ch_start  <= '0;
      timer     <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef SYS_INIT_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      en_q      <= en_n;
      done_q    <= done_q_n;
      err_mask  <= err_n;
      cur_ch    <= cur_n;
      ch_start  <= start_n;
      timer     <= timer_n;
      done      <= done_n;
      error     <= error_n;
`ifdef SYS_INIT_RETRY_EN
      retry_cnt <= retry_n;
`endif
    end
  end

endmodule

// File: tb/tb_sys_init_seq.sv
// tb/tb_sys_init_seq.sv - bench for sys_init_seq: parallel instance (timeout 100) and sequential instance (timeout 50)
`timescale 1ns/1ps
module tb_sys_init_seq;
  localparam int INF  = 1_000_000;
  localparam int TO_P = 100;
  localparam int TO_S = 50;
  localparam int MAXR = 2;
`ifdef SYS_INIT_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_v    [2];
  logic [3:0] ch_en_v    [2];
  logic [3:0] ch_done_v  [2];
  logic [3:0] ch_start_v [2];
  logic [3:0] err_mask_v [2];
  logic       busy_v     [2];
  logic       done_v     [2];
  logic       error_v    [2];
  logic [1:0] cur_v      [2];
`ifdef SYS_INIT_RETRY_EN
  logic [1:0] rc_v       [2];
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  int dly [2][4], need [2][4], rise [2][4], cnt [2][4], np [2][4];
  int r_L0 [2], r_E [2], r_err [2];
  bit r_ok [2];
  int ph_n [2], ph_L [2][16], ph_m [2][16], ph_i [2][16];
  int p_done [2], p_error [2], p_err [2], p_cur [2];
`ifdef SYS_INIT_RETRY_EN
  int ph_rc [2][16];
  int p_rc [2];
`endif

  sys_init_seq #(.NUM_CH(4), .TIMEOUT_W(24), .TIMEOUT_CYC(TO_P), .SEQ_MODE(0), .MAX_RETRY(MAXR)) dut_p (
    .clk(clk), .reset(reset), .start(start_v[0]), .ch_en(ch_en_v[0]), .ch_start(ch_start_v[0]),
    .ch_done(ch_done_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]),
    .err_mask(err_mask_v[0]), .cur_ch(cur_v[0])
`ifdef SYS_INIT_RETRY_EN
    , .retry_cnt(rc_v[0])
`endif
  );

  sys_init_seq #(.NUM_CH(4), .TIMEOUT_W(24), .TIMEOUT_CYC(TO_S), .SEQ_MODE(1), .MAX_RETRY(MAXR)) dut_s (
    .clk(clk), .reset(reset), .start(start_v[1]), .ch_en(ch_en_v[1]), .ch_start(ch_start_v[1]),
    .ch_done(ch_done_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]),
    .err_mask(err_mask_v[1]), .cur_ch(cur_v[1])
`ifdef SYS_INIT_RETRY_EN
    , .retry_cnt(rc_v[1])
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest(input int m);
    int r = 0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  // Timeline model: phases of (launch cycle, pulse mask); each channel is ready dly cycles after
  // its qualifying pulse (never before the first wait cycle); a phase times out T cycles after launch.
  task automatic model_run(input int d, input int en);
    int got, L, idx, rc, tg, pend, C, W, T;
    int rdy [4];
    int ln  [4];
    bit sq;
    sq = (d == 1);
    T = sq ? TO_S : TO_P;
    got = 0; rc = 0; L = cyc + 1;
    idx = sq ? lowest(en) : 0;
    for (int i = 0; i < 4; i++) begin rdy[i] = INF; ln[i] = 0; end
    ph_n[d] = 0; r_L0[d] = L; r_E[d] = L + 10; r_ok[d] = 1'b0; r_err[d] = 0;
    for (int k = 0; k < 16; k++) begin
      tg = sq ? (en & (1 << idx)) : en;
      pend = tg & ~got;
      ph_L[d][k] = L; ph_m[d][k] = pend; ph_i[d][k] = idx; ph_n[d] = k + 1;
`ifdef SYS_INIT_RETRY_EN
      ph_rc[d][k] = rc;
`endif
      C = L + 1;
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          ln[i]++;
          rdy[i] = (ln[i] == need[d][i] && dly[d][i] >= 0) ? L + ((dly[d][i] > 1) ? dly[d][i] : 1) : INF;
          if (rdy[i] > C) C = rdy[i];
        end
      end
      W = L + T;
      if (C <= W) begin
        got |= tg;
        if (sq && (en & ~got) != 0) begin
          idx = lowest(en & ~got); rc = 0; L = C + 1;
        end else begin
          r_E[d] = C + 1; r_ok[d] = 1'b1; r_err[d] = 0;
          break;
        end
      end else begin
        for (int i = 0; i < 4; i++) if (pend[i] && rdy[i] <= W) got |= (1 << i);
        if (RETRY && rc < MAXR) begin
          rc++; L = W + 1;
        end else begin
          r_E[d] = W + 1; r_ok[d] = 1'b0; r_err[d] = tg & ~got;
          break;
        end
      end
    end
  endtask

  function automatic int ph_at(input int d, input int t);
    int r = 0;
    for (int k = 0; k < ph_n[d]; k++) if (ph_L[d][k] <= t) r = k;
    return r;
  endfunction

  task automatic compare(input int d);
    int t, k, es, eb, ed, ee, em, ec;
`ifdef SYS_INIT_RETRY_EN
    int er;
`endif
    t = cyc;
    if (t >= r_L0[d]) begin
      k  = ph_at(d, t);
      es = (ph_L[d][k] == t && t <= r_E[d]) ? ph_m[d][k] : 0;
      eb = (t <= r_E[d]) ? 1 : 0;
      ed = (r_ok[d] && t > r_E[d]) ? 1 : 0;
      ee = (!r_ok[d] && t > r_E[d]) ? 1 : 0;
      em = (!r_ok[d] && t >= r_E[d]) ? r_err[d] : 0;
      ec = ph_i[d][k];
`ifdef SYS_INIT_RETRY_EN
      er = ph_rc[d][k];
`endif
    end else begin
      es = 0; eb = 0; ed = p_done[d]; ee = p_error[d]; em = p_err[d]; ec = p_cur[d];
`ifdef SYS_INIT_RETRY_EN
      er = p_rc[d];
`endif
    end
    chk($sformatf("dut%0d ch_start", d), int'(ch_start_v[d]), es);
    chk($sformatf("dut%0d busy", d), int'(busy_v[d]), eb);
    chk($sformatf("dut%0d done", d), int'(done_v[d]), ed);
    chk($sformatf("dut%0d error", d), int'(error_v[d]), ee);
    chk($sformatf("dut%0d err_mask", d), int'(err_mask_v[d]), em);
    chk($sformatf("dut%0d cur_ch", d), int'(cur_v[d]), ec);
`ifdef SYS_INIT_RETRY_EN
    chk($sformatf("dut%0d retry_cnt", d), int'(rc_v[d]), er);
`endif
  endtask

  task automatic commit(input int d);
    int k;
    k = ph_n[d] - 1;
    p_done[d]  = r_ok[d] ? 1 : 0;
    p_error[d] = r_ok[d] ? 0 : 1;
    p_err[d]   = r_ok[d] ? 0 : r_err[d];
    p_cur[d]   = ph_i[d][k];
`ifdef SYS_INIT_RETRY_EN
    p_rc[d]    = ph_rc[d][k];
`endif
    r_L0[d]    = INF;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      p_done[d] = 0; p_error[d] = 0; p_err[d] = 0; p_cur[d] = 0; r_L0[d] = INF; ph_n[d] = 0;
`ifdef SYS_INIT_RETRY_EN
      p_rc[d] = 0;
`endif
      for (int i = 0; i < 4; i++) begin rise[d][i] = INF; cnt[d][i] = 0; end
    end
  endtask

  // One cycle: check outputs at the falling edge, then update the sub-block models' done levels.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) compare(d);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        ch_done_v[d][i] = (cyc >= rise[d][i]);
        if (ch_start_v[d][i]) begin
          cnt[d][i]++; np[d][i]++;
          rise[d][i] = (cnt[d][i] == need[d][i] && dly[d][i] >= 0) ? cyc + dly[d][i] : INF;
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic cfg(input int d, input int a, input int b, input int c, input int e, input int n2);
    dly[d][0] = a; dly[d][1] = b; dly[d][2] = c; dly[d][3] = e;
    for (int i = 0; i < 4; i++) begin need[d][i] = (i == 2) ? n2 : 1; cnt[d][i] = 0; np[d][i] = 0; end
  endtask

  task automatic run(input int d, input int en);
    model_run(d, en);
    ch_en_v[d] = en[3:0];
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
  endtask

  task automatic finish_run(input int d);
    while (cyc <= r_E[d] + 1) step();
    commit(d);
    steps(2);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; ch_en_v[d] = '0; ch_done_v[d] = '0;
      cfg(d, 1, 1, 1, 1, 1);
    end
    model_reset();
    reset = 1'b1;
    steps(3);
    reset = 1'b0;
    steps(2);

    // Parallel: one pulse, completion at the latest responder (cycle 20).
    cfg(0, 5, 9, 20, 12, 1);
    run(0, 15);
    chk("t1 model span", r_E[0] - r_L0[0], 21);
    chk("t1 model phases", ph_n[0], 1);
    finish_run(0);
    chk("t1 done", int'(done_v[0]), 1);
    chk("t1 err_mask", int'(err_mask_v[0]), 0);

    // Sequential: channels 0,1,3 in order, channel 2 skipped.
    cfg(1, 3, 3, 3, 3, 1);
    run(1, 11);
    chk("t2 model span", r_E[1] - r_L0[1], 12);
    chk("t2 model 2nd launch", ph_L[1][1] - r_L0[1], 4);
    chk("t2 model 3rd mask", ph_m[1][2], 8);
    finish_run(1);
    chk("t2 ch2 pulses", np[1][2], 0);
    chk("t2 cur_ch", int'(cur_v[1]), 3);

    // Parallel timeout: channel 1 silent.
    cfg(0, 4, -1, 6, 1, 1);
    run(0, 7);
    chk("t3 model span", r_E[0] - r_L0[0], RETRY ? 303 : 101);
    chk("t3 model err", r_err[0], 2);
    finish_run(0);
    chk("t3 err_mask", int'(err_mask_v[0]), 2);
    chk("t3 done", int'(done_v[0]), 0);

    // Stale done levels before launch; start pulses while busy must be ignored.
    for (int i = 0; i < 4; i++) rise[0][i] = 0;
    cfg(0, 10, 1, 1, 1, 1);
    steps(2);
    run(0, 15);
    chk("t4 model span", r_E[0] - r_L0[0], 11);
    steps(4);
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    finish_run(0);
    chk("t4 pulses ch0", np[0][0], 1);

    // Empty enable mask: done three cycles after start.
    cfg(0, 1, 1, 1, 1, 1);
    run(0, 0);
    chk("en0 model span", r_E[0] - r_L0[0], 2);
    finish_run(0);
    chk("en0 done", int'(done_v[0]), 1);

    // Asynchronous reset in the middle of a wait phase.
    cfg(0, 30, 30, 30, 30, 1);
    run(0, 15);
    steps(10);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst busy", int'(busy_v[0]), 0);
    chk("rst done", int'(done_v[1]), 0);
    chk("rst error", int'(error_v[0]), 0);
    chk("rst err_mask", int'(err_mask_v[0]), 0);
    chk("rst cur_ch", int'(cur_v[1]), 0);
    model_reset();
    steps(2);
    reset = 1'b0;
    steps(2);
    cfg(0, 2, 3, 1, 1, 1);
    run(0, 3);
    chk("t5 model span", r_E[0] - r_L0[0], 4);
    finish_run(0);
    chk("t5 done", int'(done_v[0]), 1);

    // Sequential failure: channel 2 silent, channel 3 never launched.
    cfg(1, 2, 2, -1, 2, 1);
    run(1, 12);
    chk("t6 model span", r_E[1] - r_L0[1], RETRY ? 153 : 51);
    finish_run(1);
    chk("t6 err_mask", int'(err_mask_v[1]), 4);
    chk("t6 ch3 pulses", np[1][3], 0);
    chk("t6 cur_ch", int'(cur_v[1]), 2);

`ifdef SYS_INIT_RETRY_EN
    // Channel 2 answers only on its third launch.
    cfg(1, 1, 1, 5, 1, 3);
    run(1, 4);
    chk("t7 model phases", ph_n[1], 3);
    chk("t7 model span", r_E[1] - r_L0[1], 108);
    finish_run(1);
    chk("t7 ch2 pulses", np[1][2], 3);
    chk("t7 retry_cnt", int'(rc_v[1]), 2);
    chk("t7 done", int'(done_v[1]), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
